// File: rtl/seq_store_pkg.sv
// Shared types and constants for the Simon Says sequence store.
// The LFSR helpers are only used when SEQ_STORE_LFSR_EN is defined.
package seq_pkg;

  localparam int SYM_W_DEF = 2;
  localparam int DEPTH_DEF = 32;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shift Fibonacci form of x^16+x^14+x^13+x^11+1: taps on bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } play_state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/seq_store_ram.sv
// DEPTH x SYM_W symbol memory: one write port, two registered read ports
// (playback and check). Read registers clear on clr; contents never reset.
module seq_ram #(
  parameter int SYM_W = 2,
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [SYM_W-1:0] wr_data,
  input  logic             pa_en,
  input  logic [AW-1:0]    pa_addr,
  output logic [SYM_W-1:0] pa_data,
  input  logic             cb_en,
  input  logic [AW-1:0]    cb_addr,
  output logic [SYM_W-1:0] cb_data
);

  logic [SYM_W-1:0] mem_q [DEPTH];
  logic [SYM_W-1:0] pa_data_q, pa_data_d;
  logic [SYM_W-1:0] cb_data_q, cb_data_d;

  always_comb begin
    pa_data_d = pa_data_q;
    cb_data_d = cb_data_q;
    if (clr) begin
      pa_data_d = '0;
      cb_data_d = '0;
    end else begin
      if (pa_en) pa_data_d = mem_q[pa_addr];
      else       pa_data_d = pa_data_q;
      if (cb_en) cb_data_d = mem_q[cb_addr];
      else       cb_data_d = cb_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    pa_data_q <= pa_data_d;
    cb_data_q <= cb_data_d;
  end

  assign pa_data = pa_data_q;
  assign cb_data = cb_data_q;

endmodule

// File: rtl/seq_store.sv
// Simon Says sequence store: append, valid/ready playback and player check.
// Define SEQ_STORE_LFSR_EN to append LFSR-generated symbols instead of push_data.
module seq_store
  import seq_pkg::*;
#(
  parameter int SYM_W = SYM_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int LEN_W = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [SYM_W-1:0] push_data,
  output logic             full,
  output logic [LEN_W-1:0] len,
  input  logic             play_start,
  output logic             play_busy,
  output logic             play_valid,
  output logic [SYM_W-1:0] play_data,
  input  logic             play_ready,
  output logic             play_done,
  input  logic             chk_valid,
  input  logic [SYM_W-1:0] chk_data,
  output logic             chk_ok,
  output logic             chk_err,
  output logic             chk_round
);

  play_state_e      state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [AW-1:0]    play_idx_q, play_idx_d;
  logic [AW-1:0]    chk_idx_q, chk_idx_d;
  logic [SYM_W-1:0] chk_sym_q, chk_sym_d;
  logic             chk_pend_q, chk_pend_d;
  logic             chk_last_q, chk_last_d;

  logic             push_acc, chk_acc, chk_hit;
  logic [SYM_W-1:0] push_sym, chk_rd_data;

`ifdef SEQ_STORE_LFSR_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        unused_push_data;

  always_comb lfsr_d = lfsr_next(lfsr_q);

  // Seeded by rst only so that clear does not replay the same colours
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign push_sym         = lfsr_q[SYM_W-1:0];
  assign unused_push_data = ^push_data;
`else
  assign push_sym = push_data;
`endif

  assign full    = (len_q == LEN_W'(DEPTH));
  assign chk_hit = (chk_rd_data == chk_sym_q);

  always_comb begin
    push_acc = push && !clear && (state_q == IDLE) && !full;
    len_d    = len_q;
    if (clear)         len_d = '0;
    else if (push_acc) len_d = len_q + LEN_W'(1);
    else               len_d = len_q;

    // The pending result moves chk_idx before a back-to-back check reads memory
    chk_idx_d = chk_idx_q;
    if (clear)                         chk_idx_d = '0;
    else if (chk_pend_q && chk_hit && !chk_last_q) chk_idx_d = chk_idx_q + AW'(1);
    else if (chk_pend_q)               chk_idx_d = '0;
    else                               chk_idx_d = chk_idx_q;

    chk_acc    = chk_valid && !clear && (state_q == IDLE) && (len_q != '0);
    chk_pend_d = chk_acc;
    if (chk_acc) begin
      chk_sym_d  = chk_data;
      chk_last_d = (LEN_W'(chk_idx_d) == len_q - LEN_W'(1));
    end else begin
      chk_sym_d  = chk_sym_q;
      chk_last_d = chk_last_q;
    end

    state_d    = state_q;
    play_idx_d = play_idx_q;
    case (state_q)
      IDLE: begin
        if (play_start && (len_d != '0)) begin
          state_d    = FETCH;
          play_idx_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH:   state_d = PRESENT;
      PRESENT: begin
        if (!play_ready) begin
          state_d = PRESENT;
        end else if (LEN_W'(play_idx_q) == len_q - LEN_W'(1)) begin
          state_d = DONE;
        end else begin
          state_d    = FETCH;
          play_idx_d = play_idx_q + AW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d    = IDLE;
      play_idx_d = '0;
    end else begin
      play_idx_d = play_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      play_idx_q <= '0;
      chk_idx_q  <= '0;
      chk_sym_q  <= '0;
      chk_pend_q <= 1'b0;
      chk_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      play_idx_q <= play_idx_d;
      chk_idx_q  <= chk_idx_d;
      chk_sym_q  <= chk_sym_d;
      chk_pend_q <= chk_pend_d;
      chk_last_q <= chk_last_d;
    end
  end

  seq_ram #(.SYM_W(SYM_W), .DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .clr     (rst || clear),
    .wr_en   (push_acc),
    .wr_addr (len_q[AW-1:0]),
    .wr_data (push_sym),
    .pa_en   (state_q == FETCH),
    .pa_addr (play_idx_q),
    .pa_data (play_data),
    .cb_en   (chk_acc),
    .cb_addr (chk_idx_d),
    .cb_data (chk_rd_data)
  );

  assign len        = len_q;
  assign play_busy  = (state_q != IDLE);
  assign play_valid = (state_q == PRESENT);
  assign play_done  = (state_q == DONE);
  assign chk_ok     = chk_pend_q && chk_hit && !chk_last_q;
  assign chk_round  = chk_pend_q && chk_hit && chk_last_q;
  assign chk_err    = chk_pend_q && !chk_hit;

endmodule

// File: tb/tb_seq_store.sv
// Scoreboard bench for seq_store: the driver posts expectations, a negedge
// monitor pops and compares them whenever the DUT presents an output.
module tb_seq_store;

  localparam int DEPTH = 32;

  logic       clk = 1'b0;
  logic       rst, clear, push, play_start, play_ready, chk_valid;
  logic [1:0] push_data, chk_data, play_data;
  logic       full, play_busy, play_valid, play_done, chk_ok, chk_err, chk_round;
  logic [5:0] len;

  seq_store dut (
    .clk(clk), .rst(rst), .clear(clear), .push(push), .push_data(push_data),
    .full(full), .len(len), .play_start(play_start), .play_busy(play_busy),
    .play_valid(play_valid), .play_data(play_data), .play_ready(play_ready),
    .play_done(play_done), .chk_valid(chk_valid), .chk_data(chk_data),
    .chk_ok(chk_ok), .chk_err(chk_err), .chk_round(chk_round)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] sym; int cyc; } play_exp_t;
  typedef struct { logic [2:0] code; int cyc; } chk_exp_t;
  typedef struct { string name; int act; int exp; } stat_exp_t;

  play_exp_t exp_play[$];
  chk_exp_t  exp_chk[$];
  int        exp_done[$];
  stat_exp_t exp_stat[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [1:0] m_mem [DEPTH];
  int         m_len  = 0;
  int         m_cidx = 0;

  always @(posedge clk) cyc <= cyc + 1;

`ifdef SEQ_STORE_LFSR_EN
  logic [15:0] m_lfsr;
  always @(posedge clk)
    m_lfsr <= rst ? 16'hACE1 : {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
`endif

  // Monitor: all comparisons happen here
  always @(negedge clk) begin
    while (exp_stat.size() != 0) begin
      stat_exp_t s;
      s = exp_stat.pop_front();
      n_tests++;
      if (s.act != s.exp) begin
        n_fail++;
        $display("FAIL %s: got %0d expected %0d", s.name, s.act, s.exp);
      end
    end
    if (!rst) begin
      if (play_valid) begin
        n_tests++;
        if (exp_play.size() == 0) begin
          n_fail++;
          $display("FAIL play_extra: got valid data %0d expected no play_valid", play_data);
        end else begin
          if (play_data !== exp_play[0].sym || (exp_play[0].cyc >= 0 && exp_play[0].cyc != cyc)) begin
            n_fail++;
            $display("FAIL play_data: got %0d at cycle %0d expected %0d at cycle %0d",
                     play_data, cyc, exp_play[0].sym, exp_play[0].cyc);
          end
          if (play_ready) void'(exp_play.pop_front());
        end
      end
      if (play_done) begin
        n_tests++;
        if (exp_done.size() == 0) begin
          n_fail++;
          $display("FAIL play_done_extra: got pulse at cycle %0d expected none", cyc);
        end else begin
          if (exp_done[0] >= 0 && exp_done[0] != cyc) begin
            n_fail++;
            $display("FAIL play_done: got pulse at cycle %0d expected cycle %0d", cyc, exp_done[0]);
          end
          void'(exp_done.pop_front());
        end
      end
      if ({chk_round, chk_err, chk_ok} != 3'b000) begin
        n_tests++;
        if (exp_chk.size() == 0) begin
          n_fail++;
          $display("FAIL chk_extra: got {round,err,ok}=%b expected no pulse", {chk_round, chk_err, chk_ok});
        end else begin
          if ({chk_round, chk_err, chk_ok} != exp_chk[0].code || exp_chk[0].cyc != cyc) begin
            n_fail++;
            $display("FAIL chk_result: got %b at cycle %0d expected %b at cycle %0d",
                     {chk_round, chk_err, chk_ok}, cyc, exp_chk[0].code, exp_chk[0].cyc);
          end
          void'(exp_chk.pop_front());
        end
      end
    end
  end

  task automatic post(input string name, input int act, input int exp);
    exp_stat.push_back('{name, act, exp});
  endtask

  task automatic step();
    @(negedge clk);
    push = 1'b0; play_start = 1'b0; chk_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic set_push(input logic [1:0] d);
    logic [1:0] sym;
    push = 1'b1; push_data = d;
`ifdef SEQ_STORE_LFSR_EN
    sym = m_lfsr[1:0];
`else
    sym = d;
`endif
    if (m_len < DEPTH) begin
      m_mem[m_len] = sym;
      m_len++;
    end
  endtask

  task automatic set_play(input bit stamped);
    play_start = 1'b1;
    if (m_len != 0) begin
      for (int i = 0; i < m_len; i++)
        exp_play.push_back('{m_mem[i], stamped ? cyc + 2 * i + 2 : -1});
      exp_done.push_back(stamped ? cyc + 2 * m_len + 1 : -1);
    end
  endtask

  task automatic set_chk(input logic [1:0] d);
    chk_valid = 1'b1; chk_data = d;
    if (m_len != 0) begin
      if (d != m_mem[m_cidx]) begin
        exp_chk.push_back('{3'b010, cyc + 1}); m_cidx = 0;
      end else if (m_cidx == m_len - 1) begin
        exp_chk.push_back('{3'b100, cyc + 1}); m_cidx = 0;
      end else begin
        exp_chk.push_back('{3'b001, cyc + 1}); m_cidx++;
      end
    end
  endtask

  task automatic set_clear();
    clear = 1'b1; m_len = 0; m_cidx = 0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (play_busy && k < 200) begin
      step();
      k++;
    end
    post("play_idle_timeout", int'(play_busy), 0);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; push = 1'b0; push_data = 2'd0; play_start = 1'b0;
    play_ready = 1'b1; chk_valid = 1'b0; chk_data = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    post("rst_len", int'(len), 0);
    post("rst_full", int'(full), 0);
    post("rst_busy", int'(play_busy), 0);
    post("rst_play_data", int'(play_data), 0);
    post("rst_pulses", int'({play_valid, play_done, chk_ok, chk_err, chk_round}), 0);

    // Clear after three pushes; start and check with empty store are ignored
    set_push(2'd1); step(); set_push(2'd2); step(); set_push(2'd3); step();
    post("push3_len", int'(len), 3);
    set_clear(); step();
    post("clear_len", int'(len), 0);
    post("clear_full", int'(full), 0);
    set_play(1'b1); step();
    set_chk(2'd0); step(); step();
    post("empty_start_busy", int'(play_busy), 0);

    // Basic playback with ready tied high
    set_push(2'd2); step(); set_push(2'd0); step(); set_push(2'd3); step();
    post("push_len", int'(len), 3);
    set_play(1'b1); step();
    wait_idle();

    // Backpressure: data held while ready is low
    play_ready = 1'b0;
    set_play(1'b0); step();
    repeat (6) step();
    post("bp_valid_held", int'(play_valid), 1);
    post("bp_data_held", int'(play_data), int'(m_mem[0]));
    play_ready = 1'b1;
    wait_idle();

    // Back-to-back checks: ok, ok, round, then ok, err, then idx 0 again
    set_chk(2'd2); step(); set_chk(2'd0); step(); set_chk(2'd3); step();
    set_chk(2'd2); step(); set_chk(2'd1); step();
    set_chk(2'd2); step(); set_chk(2'd0); step(); set_chk(2'd3); step();
    step();

    // Push and start in the same cycle: playback covers the new entry
    set_push(2'd1); set_play(1'b1); step();
    wait_idle();
    post("push_play_len", int'(len), 4);

    // Start while a check result is pending; check during playback ignored
    set_chk(2'd2); step();
    set_play(1'b1); step();
    chk_valid = 1'b1; chk_data = 2'd0; step();
    wait_idle();

    // Fill to capacity, overflow push ignored, then push+clear together
    set_clear(); step();
    for (int i = 0; i < DEPTH + 1; i++) begin
      set_push(2'(i)); step();
    end
    post("fill_len", int'(len), DEPTH);
    post("fill_full", int'(full), 1);
    set_push(2'd1); set_clear(); step();
    post("push_clear_len", int'(len), 0);
    post("push_clear_full", int'(full), 0);

    // Reset mid-run, then four fresh pushes played back and checked
    rst = 1'b1; step(); step(); rst = 1'b0;
    m_len = 0; m_cidx = 0;
    post("rerst_len", int'(len), 0);
    set_push(2'd3); step(); set_push(2'd1); step(); set_push(2'd2); step(); set_push(2'd0); step();
    set_play(1'b1); step();
    wait_idle();
    set_chk(2'd3); step(); set_chk(2'd1); step(); set_chk(2'd2); step(); set_chk(2'd0); step();
    repeat (3) step();

    post("left_play", exp_play.size(), 0);
    post("left_done", exp_done.size(), 0);
    post("left_chk", exp_chk.size(), 0);
    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
